// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t    : FSM encoding (S_FETCH, S_VALID, S_DRAIN)
//   PC_STEP/PC_SKIP  : sequential and skip PC increments (bytes)
//   RESET_PC_DEFAULT : default PC loaded on reset
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // demand fetch of pc in progress, no valid instruction
    S_VALID = 2'd1,  // instruction at pc presented to the control unit
    S_DRAIN = 2'd2   // waiting out a stale prefetch after a redirect
  } fetch_state_t;

  localparam int PC_STEP = 2;
  localparam int PC_SKIP = 4;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/inst_fetch_unit_pc_next_calc.sv
// Combinational next-PC selection for the fetch unit.
// Ports:
//   pc            : current PC
//   pc_2_en       : skip the following word (pc + PC_SKIP)
//   branch_en     : load branch_target (takes priority over pc_2_en)
//   branch_target : jump address
//   next_pc       : selected next PC, modulo 2^ADDR_W
module pc_next_calc
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_2_en,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] next_pc
);

  // Next-PC mux; the adders wrap naturally at ADDR_W bits.
  always_comb begin
    next_pc = pc + ADDR_W'(PC_STEP);
    if (branch_en) begin
      next_pc = branch_target;
    end else if (pc_2_en) begin
      next_pc = pc + ADDR_W'(PC_SKIP);
    end else begin
      next_pc = pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches 16-bit instructions over
// a req/ack memory handshake and keeps a one-entry sequential prefetch buffer
// so straight-line code advances without a bubble.
// Ports:
//   clk, rst                  : clock, async active-low reset
//   pc_inc, pc_2_en,          : control unit advance request and qualifiers
//   branch_en, branch_target
//   halt                      : suppress new memory requests
//   imem_req, imem_addr       : registered memory request (held until ack)
//   imem_ack, imem_rdata      : memory response, data sampled in ack cycle
//   instruction, inst_valid,  : presented instruction and its address
//   pc
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_inc,
  input  logic              pc_2_en,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] instruction,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_t      state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              imem_req_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [DATA_W-1:0] instruction_r;
  logic              inst_valid_r;
  logic              buf_valid_r;
  logic [DATA_W-1:0] buf_data_r;

  logic              ack_s;
  logic              redirect_s;
  logic [ADDR_W-1:0] seq_pc_s;
  logic [ADDR_W-1:0] next_pc_s;

  // An ack only counts while our own request is open, so a late ack from a
  // request abandoned by reset is ignored.
  assign ack_s      = imem_ack & imem_req_r;
  assign redirect_s = pc_2_en | branch_en;
  assign seq_pc_s   = pc_r + ADDR_W'(PC_STEP);

  pc_next_calc #(
    .ADDR_W(ADDR_W)
  ) u_pc_next_calc (
    .pc           (pc_r),
    .pc_2_en      (pc_2_en),
    .branch_en    (branch_en),
    .branch_target(branch_target),
    .next_pc      (next_pc_s)
  );

  // Fetch FSM with PC, request, prefetch buffer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= S_FETCH;
      pc_r          <= RESET_PC;
      imem_req_r    <= 1'b0;
      imem_addr_r   <= RESET_PC;
      instruction_r <= {DATA_W{1'b0}};
      inst_valid_r  <= 1'b0;
      buf_valid_r   <= 1'b0;
      buf_data_r    <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        S_FETCH: begin
          if (imem_req_r) begin
            if (ack_s) begin
              instruction_r <= imem_rdata;
              inst_valid_r  <= 1'b1;
              imem_req_r    <= 1'b0;
              state_r       <= S_VALID;
            end
          end else if (!halt) begin
            imem_req_r  <= 1'b1;
            imem_addr_r <= pc_r;
          end
        end

        S_VALID: begin
          if (pc_inc) begin
            pc_r        <= next_pc_s;
            buf_valid_r <= 1'b0;
            if (!redirect_s && buf_valid_r) begin
              // Buffered word is exactly pc+2: advance with no bubble.
              instruction_r <= buf_data_r;
            end else if (!redirect_s && ack_s) begin
              // Prefetch lands in the consuming cycle: bypass it.
              instruction_r <= imem_rdata;
              imem_req_r    <= 1'b0;
            end else if (imem_req_r && !ack_s) begin
              // Sequential: the in-flight prefetch becomes the demand fetch.
              // Redirect: its data is stale and must be drained.
              inst_valid_r <= 1'b0;
              state_r      <= redirect_s ? S_DRAIN : S_FETCH;
            end else begin
              inst_valid_r <= 1'b0;
              state_r      <= S_FETCH;
              if (ack_s) begin
                // Redirect coinciding with an ack: drop the data, close req.
                imem_req_r <= 1'b0;
              end else if (!halt) begin
                imem_req_r  <= 1'b1;
                imem_addr_r <= next_pc_s;
              end
            end
          end else begin
            if (ack_s) begin
              buf_data_r  <= imem_rdata;
              buf_valid_r <= 1'b1;
              imem_req_r  <= 1'b0;
            end else if (!imem_req_r && !buf_valid_r && !halt) begin
              imem_req_r  <= 1'b1;
              imem_addr_r <= seq_pc_s;
            end
          end
        end

        S_DRAIN: begin
          inst_valid_r <= 1'b0;
          if (ack_s) begin
            imem_req_r <= 1'b0;
            state_r    <= S_FETCH;
          end
        end

        default: begin
          state_r      <= S_FETCH;
          imem_req_r   <= 1'b0;
          inst_valid_r <= 1'b0;
          buf_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign instruction = instruction_r;
  assign inst_valid  = inst_valid_r;
  assign pc          = pc_r;

endmodule
